// File: rtl/crc32_hash_arbiter.sv
// Two key requesters share one CRC32_D32 core (poly 04C11DB7, MSB-first) under round-robin arbitration.
// Define CRC_HASH_SEED_PORT_EN to add per-requester seed inputs that replace SEED.
module crc32_hash_arbiter #(
    parameter logic [31:0] SEED      = 32'hFFFF_FFFF,
    parameter logic [31:0] FINAL_XOR = 32'hFFFF_FFFF,
    parameter int unsigned MAX_WORDS = 16,
    localparam int unsigned LEN_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [31:0]      req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
`ifdef CRC_HASH_SEED_PORT_EN
    input  logic [31:0]      req0_seed,
    input  logic [31:0]      req1_seed,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_crc,
    output logic             res_id,
    output logic [LEN_W-1:0] res_len,
    output logic             res_err
);

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic             rr_q;
    logic             owner_q;
    logic [31:0]      crc_q;
    logic [LEN_W-1:0] cnt_q;
    logic             err_q;
    logic             ready0_q;
    logic             ready1_q;
    logic             res_valid_q;
    logic [31:0]      res_crc_q;
    logic             res_id_q;
    logic [LEN_W-1:0] res_len_q;
    logic             res_err_q;

    logic             own_valid_c;
    logic [31:0]      own_data_c;
    logic             own_last_c;
    logic             beat_acc_c;
    logic             gnt_id_c;
    logic             at_max_c;
    logic [31:0]      seed_c;
    logic [31:0]      crc_d;
    logic [LEN_W-1:0] cnt_d;
    logic             err_d;

    // One 32-bit data word folded into the CRC register, MSB first.
    function automatic logic [31:0] crc32_d32(input logic [31:0] d, input logic [31:0] c);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? POLY : 32'h0);
        end
        return r;
    endfunction

    assign own_valid_c = owner_q ? req1_valid : req0_valid;
    assign own_data_c  = owner_q ? req1_data  : req0_data;
    assign own_last_c  = owner_q ? req1_last  : req0_last;
    assign beat_acc_c  = own_valid_c & (owner_q ? ready1_q : ready0_q);
    assign gnt_id_c    = (req0_valid & req1_valid) ? rr_q : req1_valid;
    assign at_max_c    = (cnt_q == LEN_W'(MAX_WORDS));
    assign crc_d       = crc32_d32(own_data_c, crc_q);
    assign cnt_d       = at_max_c ? cnt_q : cnt_q + LEN_W'(1);
    assign err_d       = err_q | at_max_c;

`ifdef CRC_HASH_SEED_PORT_EN
    assign seed_c = gnt_id_c ? req1_seed : req0_seed;
`else
    assign seed_c = SEED;
`endif

    // Arbitration, beat folding and result hold-until-accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            crc_q       <= SEED;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_crc_q   <= 32'h0;
            res_id_q    <= 1'b0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_valid | req1_valid) begin
                        owner_q  <= gnt_id_c;
                        crc_q    <= seed_c;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        ready0_q <= ~gnt_id_c;
                        ready1_q <= gnt_id_c;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (beat_acc_c) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_d;
                        err_q <= err_d;
                        if (own_last_c) begin
                            ready0_q    <= 1'b0;
                            ready1_q    <= 1'b0;
                            res_valid_q <= 1'b1;
                            res_crc_q   <= crc_d ^ FINAL_XOR;
                            res_id_q    <= owner_q;
                            res_len_q   <= cnt_d;
                            res_err_q   <= err_d;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        rr_q        <= ~owner_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign res_valid  = res_valid_q;
    assign res_crc    = res_crc_q;
    assign res_id     = res_id_q;
    assign res_len    = res_len_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_crc32_hash_arbiter.sv
// Bench for crc32_hash_arbiter: two instances (MAX_WORDS=4 default seed, and SEED=0/FINAL_XOR=0) share stimulus.
// Reference uses polynomial long division for the CRC and a transaction-level view of grant/serve/present.
module tb_crc32_hash_arbiter;

    localparam int unsigned LA   = 3;
    localparam int unsigned LB   = 5;
    localparam int unsigned MAXK = 24;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_last, req1_valid, req1_last, res_ready;
    logic [31:0] req0_data, req1_data;

    logic          a_rdy0, a_rdy1, a_rv, a_id, a_err;
    logic [31:0]   a_crc;
    logic [LA-1:0] a_len;
    logic          b_rdy0, b_rdy1, b_rv, b_id, b_err;
    logic [31:0]   b_crc;
    logic [LB-1:0] b_len;

    crc32_hash_arbiter #(.MAX_WORDS(4)) u_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(a_rdy0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(a_rdy1),
`ifdef CRC_HASH_SEED_PORT_EN
        .req0_seed(32'hFFFF_FFFF), .req1_seed(32'hFFFF_FFFF),
`endif
        .res_valid(a_rv), .res_ready(res_ready), .res_crc(a_crc), .res_id(a_id),
        .res_len(a_len), .res_err(a_err)
    );

    crc32_hash_arbiter #(.SEED(32'h0), .FINAL_XOR(32'h0), .MAX_WORDS(16)) u_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(b_rdy0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(b_rdy1),
`ifdef CRC_HASH_SEED_PORT_EN
        .req0_seed(32'h0), .req1_seed(32'h0),
`endif
        .res_valid(b_rv), .res_ready(res_ready), .res_crc(b_crc), .res_id(b_id),
        .res_len(b_len), .res_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // CRC step as remainder of (crc ^ word) * x^32 modulo the generator polynomial.
    function automatic logic [31:0] crc_step(input logic [31:0] w, input logic [31:0] c);
        logic [63:0] m;
        m = {c ^ w, 32'h0};
        for (int b = 63; b >= 32; b--) begin
            if (m[b]) m = m ^ ({31'h0, 33'h1_04C1_1DB7} << (b - 32));
        end
        return m[31:0];
    endfunction

    // reference state: 0 = waiting for requests, 1 = serving owner, 2 = presenting result
    int          ph, own, rr, mn;
    logic [31:0] ca, cb;
    logic [31:0] e_a_crc, e_b_crc;
    logic        e_id, e_a_err, e_b_err;
    int          e_a_len, e_b_len;

    logic [31:0] cap_a_crc, cap_b_crc;
    logic        cap_a_id, cap_b_id, cap_a_err, cap_b_err;
    int          cap_a_len, cap_b_len;

    logic [31:0] wq0[$], wq1[$];
    int          lq0[$], lq1[$];
    logic [31:0] cur_w [2][MAXK];
    int          cur_len [2];
    int          cur_idx [2];
    bit          act [2];

    int gap_pct, start_pct, rr_mode, st_left, rst_arm, rst_hits, hold_cnt;
    bit force_rst;

    bit          p_v [2];
    logic [31:0] p_d [2];
    bit          p_l [2];
    bit          p_rr, p_rst;

    task automatic add_key(input int r, input int n, input logic [31:0] w0, input logic [31:0] w1, input bit rnd);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            if (rnd || i > 1) w = $urandom;
            else w = (i == 0) ? w0 : w1;
            if (r == 0) wq0.push_back(w); else wq1.push_back(w);
        end
        if (r == 0) lq0.push_back(n); else lq1.push_back(n);
    endtask

    task automatic load(input int r);
        if (r == 0) begin
            cur_len[0] = lq0.pop_front();
            for (int i = 0; i < cur_len[0]; i++) cur_w[0][i] = wq0.pop_front();
        end else begin
            cur_len[1] = lq1.pop_front();
            for (int i = 0; i < cur_len[1]; i++) cur_w[1][i] = wq1.pop_front();
        end
        cur_idx[r] = 0;
        act[r]     = 1'b1;
    endtask

    task automatic step();
        bit do_rst;
        bit v;
        int qs;
        @(negedge clk);
        if (p_rst) begin
            ph = 0; rr = 0; mn = 0;
            e_id = 1'b0; e_a_crc = 32'h0; e_b_crc = 32'h0;
            e_a_len = 0; e_b_len = 0; e_a_err = 1'b0; e_b_err = 1'b0;
        end else begin
            case (ph)
                0: if (p_v[0] || p_v[1]) begin
                    own = (p_v[0] && p_v[1]) ? rr : (p_v[1] ? 1 : 0);
                    ph = 1; mn = 0; ca = 32'hFFFF_FFFF; cb = 32'h0;
                end
                1: if (p_v[own]) begin
                    ca = crc_step(p_d[own], ca);
                    cb = crc_step(p_d[own], cb);
                    mn++;
                    cur_idx[own]++;
                    if (p_l[own]) begin
                        act[own] = 1'b0;
                        ph = 2; hold_cnt = 0;
                        e_id    = 1'(own);
                        e_a_crc = ca ^ 32'hFFFF_FFFF;
                        e_b_crc = cb;
                        e_a_len = (mn > 4) ? 4 : mn;
                        e_a_err = (mn > 4);
                        e_b_len = (mn > 16) ? 16 : mn;
                        e_b_err = (mn > 16);
                    end
                end
                default: if (p_rr) begin
                    rr = 1 - own;
                    ph = 0;
                end
            endcase
        end

        check("a_rdy0", 32'(a_rdy0), 32'(ph == 1 && own == 0));
        check("a_rdy1", 32'(a_rdy1), 32'(ph == 1 && own == 1));
        check("b_rdy0", 32'(b_rdy0), 32'(ph == 1 && own == 0));
        check("b_rdy1", 32'(b_rdy1), 32'(ph == 1 && own == 1));
        check("a_res_valid", 32'(a_rv), 32'(ph == 2));
        check("b_res_valid", 32'(b_rv), 32'(ph == 2));
        if (ph == 2 || p_rst) begin
            check("a_res_crc", a_crc, e_a_crc);
            check("a_res_id",  32'(a_id),  32'(e_id));
            check("a_res_len", 32'(a_len), 32'(e_a_len));
            check("a_res_err", 32'(a_err), 32'(e_a_err));
            check("b_res_crc", b_crc, e_b_crc);
            check("b_res_id",  32'(b_id),  32'(e_id));
            check("b_res_len", 32'(b_len), 32'(e_b_len));
            check("b_res_err", 32'(b_err), 32'(e_b_err));
        end
        if (ph == 2) begin
            cap_a_crc = a_crc; cap_a_id = a_id; cap_a_len = int'(a_len); cap_a_err = a_err;
            cap_b_crc = b_crc; cap_b_id = b_id; cap_b_len = int'(b_len); cap_b_err = b_err;
        end

        do_rst = force_rst;
        force_rst = 1'b0;
        if (rst_arm != 0 && ph == 1 && mn == rst_arm) begin
            do_rst = 1'b1; rst_arm = 0; rst_hits++;
        end
        rst   = do_rst;
        p_rst = do_rst;
        for (int r = 0; r < 2; r++) begin
            qs = (r == 0) ? lq0.size() : lq1.size();
            if (do_rst) act[r] = 1'b0;
            else if (!act[r] && qs > 0 && $urandom_range(99) < start_pct) load(r);
            v = act[r] && !do_rst && ($urandom_range(99) >= gap_pct);
            if (act[r] && cur_idx[r] == 1 && st_left > 0) begin
                v = 1'b0; st_left--;
            end
            p_v[r] = v;
            p_d[r] = act[r] ? cur_w[r][cur_idx[r]] : $urandom;
            p_l[r] = act[r] ? (cur_idx[r] == cur_len[r] - 1) : 1'($urandom_range(1));
        end
        req0_valid = p_v[0]; req0_data = p_d[0]; req0_last = p_l[0];
        req1_valid = p_v[1]; req1_data = p_d[1]; req1_last = p_l[1];
        case (rr_mode)
            0:       p_rr = 1'($urandom_range(1));
            1:       p_rr = 1'b1;
            default: p_rr = (ph == 2 && hold_cnt >= 5);
        endcase
        if (do_rst) p_rr = 1'b0;
        res_ready = p_rr;
        if (ph == 2) hold_cnt++;
    endtask

    task automatic run_idle(input int budget);
        int  k;
        bit  done;
        k = 0; done = 1'b0;
        while (!done && k < budget) begin
            step();
            k++;
            done = (lq0.size() == 0 && lq1.size() == 0 && !act[0] && !act[1] && ph == 0);
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; p_rst = 1'b1;
        req0_valid = 1'b0; req0_data = 32'h0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 32'h0; req1_last = 1'b0;
        res_ready = 1'b0; p_rr = 1'b0;
        for (int r = 0; r < 2; r++) begin
            p_v[r] = 1'b0; p_d[r] = 32'h0; p_l[r] = 1'b0;
            act[r] = 1'b0; cur_idx[r] = 0; cur_len[r] = 0;
        end
        ph = 0; own = 0; rr = 0; mn = 0; ca = 32'h0; cb = 32'h0;
        gap_pct = 0; start_pct = 100; rr_mode = 1; st_left = 0;
        rst_arm = 0; rst_hits = 0; hold_cnt = 0; force_rst = 1'b0;

        step();

        // single beat of 1 from seed 0 yields the polynomial itself
        add_key(0, 1, 32'h0000_0001, 32'h0, 1'b0);
        run_idle(50);
        check("tp1_crc", cap_b_crc, 32'h04C1_1DB7);
        check("tp1_id",  32'(cap_b_id), 32'd0);
        check("tp1_len", 32'(cap_b_len), 32'd1);
        check("tp1_err", 32'(cap_b_err), 32'd0);

        add_key(1, 1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_idle(50);
        check("tp2_crc", cap_a_crc, 32'hFFFF_FFFF);
        check("tp2_id",  32'(cap_a_id), 32'd1);
        check("tp2_len", 32'(cap_a_len), 32'd1);

        st_left = 2;
        add_key(0, 2, 32'h0000_0001, 32'h04C1_1DB7, 1'b0);
        run_idle(50);
        check("tp3_crc", cap_b_crc, 32'h0);
        check("tp3_len", 32'(cap_b_len), 32'd2);

        // contention from reset: pointer starts at requester 0 and alternates
        force_rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            add_key(0, 1, 32'h0, 32'h0, 1'b1);
            add_key(1, 1, 32'h0, 32'h0, 1'b1);
        end
        run_idle(200);

        rr_mode = 2;
        add_key(1, 2, 32'h0, 32'h0, 1'b1);
        run_idle(60);
        rr_mode = 1;

        add_key(0, 6, 32'h0, 32'h0, 1'b1);
        run_idle(60);
        check("ovf_a_len", 32'(cap_a_len), 32'd4);
        check("ovf_a_err", 32'(cap_a_err), 32'd1);
        check("ovf_b_len", 32'(cap_b_len), 32'd6);
        check("ovf_b_err", 32'(cap_b_err), 32'd0);

        add_key(1, 4, 32'h0, 32'h0, 1'b1);
        run_idle(60);
        check("max_a_len", 32'(cap_a_len), 32'd4);
        check("max_a_err", 32'(cap_a_err), 32'd0);

        // reset after two beats of a three-beat key: nothing must come out
        rst_arm = 2;
        add_key(0, 3, 32'h0, 32'h0, 1'b1);
        run_idle(60);
        check("rst_hit", 32'(rst_hits), 32'd1);
        repeat (6) step();
        add_key(0, 1, 32'h0000_0001, 32'h0, 1'b0);
        run_idle(50);
        check("post_rst_crc", cap_b_crc, 32'h04C1_1DB7);

        gap_pct = 25; start_pct = 70; rr_mode = 0;
        for (int k = 0; k < 300; k++) begin
            add_key(int'($urandom_range(1)), int'($urandom_range(7, 1)), 32'h0, 32'h0, 1'b1);
        end
        run_idle(30000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
